// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MEM pipeline stage with stalling, timed-out data-memory handshake.
module mem_access_stage #(
  parameter int data_width = 32,
  parameter int op_width   = 5,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_rd_m,
  input  logic                  mem_wr_m,
  input  logic                  reg_wr_m,
  input  logic                  mem2reg_m,
  input  logic [op_width-1:0]   write_reg_m,
  input  logic [data_width-1:0] alu_result_m,
  input  logic [data_width-1:0] write_data_m,
  input  logic                  dmem_ack,
  input  logic [data_width-1:0] dmem_rdata,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [data_width-1:0] dmem_addr,
  output logic [data_width-1:0] dmem_wdata,
  output logic                  stall_m,
  output logic                  reg_wr_out,
  output logic                  mem2reg_out,
  output logic [op_width-1:0]   write_reg_out,
  output logic [data_width-1:0] alu_result_out,
  output logic [data_width-1:0] data,
  output logic                  bus_err
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT - 1);

  state_t                state;
  logic [data_width-1:0] rdata_q;
  logic [7:0]            count;
  logic                  access;
  logic                  aligned;

  assign access  = mem_rd_m | mem_wr_m;
  assign aligned = (alu_result_m[1:0] == 2'b00);

  assign mem2reg_out    = mem2reg_m;
  assign write_reg_out  = write_reg_m;
  assign alu_result_out = alu_result_m;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      rdata_q    <= '0;
      count      <= '0;
      bus_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (access) begin
            if (aligned) begin
              // mem_wr_m alone decides direction, so rd+wr together is a store
              dmem_req   <= 1'b1;
              dmem_we    <= mem_wr_m;
              dmem_addr  <= alu_result_m;
              dmem_wdata <= write_data_m;
              count      <= '0;
              state      <= ACCESS;
            end else begin
              rdata_q <= '0;
              bus_err <= 1'b1;
              state   <= DONE;
            end
          end
        end
        ACCESS: begin
          if (dmem_ack) begin
            rdata_q  <= dmem_we ? '0 : dmem_rdata;
            dmem_req <= 1'b0;
            state    <= DONE;
          end else if (count == LAST_COUNT) begin
            dmem_req <= 1'b0;
            rdata_q  <= '0;
            bus_err  <= 1'b1;
            state    <= DONE;
          end else begin
            count <= count + 8'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    stall_m    = 1'b0;
    reg_wr_out = reg_wr_m;
    data       = '0;
    case (state)
      IDLE: begin
        if (access) begin
          stall_m    = 1'b1;
          reg_wr_out = 1'b0;
        end
      end
      ACCESS: begin
        stall_m    = 1'b1;
        reg_wr_out = 1'b0;
      end
      DONE:    data = rdata_q;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - directed bench for mem_access_stage.
module tb_mem_access_stage;

  logic        clk;
  logic        reset;
  logic        mem_rd_m, mem_wr_m, reg_wr_m, mem2reg_m;
  logic [4:0]  write_reg_m;
  logic [31:0] alu_result_m, write_data_m;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        stall_m, reg_wr_out, mem2reg_out;
  logic [4:0]  write_reg_out;
  logic [31:0] alu_result_out, data;
  logic        bus_err;

  int errors = 0;
  int checks = 0;

  mem_access_stage #(.data_width(32), .op_width(5), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .mem_rd_m(mem_rd_m), .mem_wr_m(mem_wr_m), .reg_wr_m(reg_wr_m), .mem2reg_m(mem2reg_m),
    .write_reg_m(write_reg_m), .alu_result_m(alu_result_m), .write_data_m(write_data_m),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .stall_m(stall_m), .reg_wr_out(reg_wr_out), .mem2reg_out(mem2reg_out),
    .write_reg_out(write_reg_out), .alu_result_out(alu_result_out), .data(data),
    .bus_err(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        reg_wr;
    logic        mem2reg;
    logic [4:0]  wreg;
    logic [31:0] alu;
    logic        exp_reg_wr;
    logic        exp_mem2reg;
    logic [4:0]  exp_wreg;
    logic [31:0] exp_alu;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mem_rd_m = 0; mem_wr_m = 0; reg_wr_m = 0; mem2reg_m = 0;
    write_reg_m = 0; alu_result_m = 0; write_data_m = 0;
    dmem_ack = 0; dmem_rdata = 0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    vecs[0] = '{1'b1, 1'b0, 5'd5,  32'h0000_1234, 1'b1, 1'b0, 5'd5,  32'h0000_1234};
    vecs[1] = '{1'b0, 1'b1, 5'd31, 32'hFFFF_FFFC, 1'b0, 1'b1, 5'd31, 32'hFFFF_FFFC};
    vecs[2] = '{1'b1, 1'b1, 5'd0,  32'h0000_0003, 1'b1, 1'b1, 5'd0,  32'h0000_0003};
    vecs[3] = '{1'b0, 1'b0, 5'd17, 32'h8000_0001, 1'b0, 1'b0, 5'd17, 32'h8000_0001};

    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset dmem_req", 32'(dmem_req), 32'd0);
    chk("reset dmem_we", 32'(dmem_we), 32'd0);
    chk("reset dmem_addr", dmem_addr, 32'd0);
    chk("reset dmem_wdata", dmem_wdata, 32'd0);
    chk("reset bus_err", 32'(bus_err), 32'd0);
    chk("reset stall_m", 32'(stall_m), 32'd0);
    chk("reset data", data, 32'd0);
    reset = 1'b0;
    tick();

    // Non-memory ops: same-cycle passthrough, no request
    for (int i = 0; i < 4; i++) begin
      reg_wr_m = vecs[i].reg_wr; mem2reg_m = vecs[i].mem2reg;
      write_reg_m = vecs[i].wreg; alu_result_m = vecs[i].alu;
      #1;
      chk($sformatf("vec%0d reg_wr_out", i), 32'(reg_wr_out), 32'(vecs[i].exp_reg_wr));
      chk($sformatf("vec%0d mem2reg_out", i), 32'(mem2reg_out), 32'(vecs[i].exp_mem2reg));
      chk($sformatf("vec%0d write_reg_out", i), 32'(write_reg_out), 32'(vecs[i].exp_wreg));
      chk($sformatf("vec%0d alu_result_out", i), alu_result_out, vecs[i].exp_alu);
      chk($sformatf("vec%0d stall_m", i), 32'(stall_m), 32'd0);
      chk($sformatf("vec%0d data", i), data, 32'd0);
      tick();
      chk($sformatf("vec%0d no dmem_req", i), 32'(dmem_req), 32'd0);
      chk($sformatf("vec%0d no bus_err", i), 32'(bus_err), 32'd0);
    end

    // Stray ack while idle is ignored
    idle_inputs();
    dmem_ack = 1; dmem_rdata = 32'h5555_5555;
    tick();
    dmem_ack = 0;
    chk("idle ack stall_m", 32'(stall_m), 32'd0);
    chk("idle ack data", data, 32'd0);
    chk("idle ack dmem_req", 32'(dmem_req), 32'd0);

    // Load 0x100, ack one cycle after request
    mem_rd_m = 1; reg_wr_m = 1; mem2reg_m = 1; write_reg_m = 5'd3; alu_result_m = 32'h100;
    #1;
    chk("ld detect stall_m", 32'(stall_m), 32'd1);
    chk("ld detect reg_wr_out", 32'(reg_wr_out), 32'd0);
    chk("ld detect dmem_req", 32'(dmem_req), 32'd0);
    tick();
    chk("ld acc1 dmem_req", 32'(dmem_req), 32'd1);
    chk("ld acc1 dmem_we", 32'(dmem_we), 32'd0);
    chk("ld acc1 dmem_addr", dmem_addr, 32'h100);
    chk("ld acc1 stall_m", 32'(stall_m), 32'd1);
    tick();
    dmem_ack = 1; dmem_rdata = 32'hDEAD_BEEF;
    chk("ld acc2 stall_m", 32'(stall_m), 32'd1);
    chk("ld acc2 reg_wr_out", 32'(reg_wr_out), 32'd0);
    tick();
    dmem_ack = 0; dmem_rdata = 0;
    chk("ld done stall_m", 32'(stall_m), 32'd0);
    chk("ld done data", data, 32'hDEAD_BEEF);
    chk("ld done reg_wr_out", 32'(reg_wr_out), 32'd1);
    chk("ld done dmem_req", 32'(dmem_req), 32'd0);
    idle_inputs();
    tick();
    chk("ld after data", data, 32'd0);
    chk("ld after stall_m", 32'(stall_m), 32'd0);

    // Store 0x200; request fields must hold while waiting
    mem_wr_m = 1; alu_result_m = 32'h200; write_data_m = 32'hA5A5_A5A5;
    tick();
    alu_result_m = 32'h0000_0BB0; write_data_m = 32'h0F0F_0F0F;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("st wait%0d dmem_req", i), 32'(dmem_req), 32'd1);
      chk($sformatf("st wait%0d dmem_we", i), 32'(dmem_we), 32'd1);
      chk($sformatf("st wait%0d dmem_addr", i), dmem_addr, 32'h200);
      chk($sformatf("st wait%0d dmem_wdata", i), dmem_wdata, 32'hA5A5_A5A5);
      if (i == 2) begin
        dmem_ack = 1; dmem_rdata = 32'h1234_5678;
      end
      tick();
    end
    dmem_ack = 0;
    chk("st done data", data, 32'd0);
    chk("st done stall_m", 32'(stall_m), 32'd0);
    idle_inputs();
    tick();

    // rd+wr together is a store; same-cycle ack gives 2 stall cycles
    mem_rd_m = 1; mem_wr_m = 1; alu_result_m = 32'h300; write_data_m = 32'h0000_00AB;
    #1;
    chk("rw detect stall_m", 32'(stall_m), 32'd1);
    tick();
    chk("rw dmem_we", 32'(dmem_we), 32'd1);
    chk("rw acc stall_m", 32'(stall_m), 32'd1);
    dmem_ack = 1; dmem_rdata = 32'hFFFF_FFFF;
    tick();
    dmem_ack = 0;
    chk("rw done stall_m", 32'(stall_m), 32'd0);
    chk("rw done data", data, 32'd0);
    idle_inputs();
    tick();

    // Aligned load with same-cycle ack
    mem_rd_m = 1; reg_wr_m = 1; alu_result_m = 32'h104;
    tick();
    dmem_ack = 1; dmem_rdata = 32'h0BAD_F00D;
    chk("ld0 acc stall_m", 32'(stall_m), 32'd1);
    tick();
    dmem_ack = 0;
    chk("ld0 done data", data, 32'h0BAD_F00D);
    chk("ld0 done stall_m", 32'(stall_m), 32'd0);
    idle_inputs();
    tick();

    // Reset mid-ACCESS, then a late ack
    mem_rd_m = 1; alu_result_m = 32'h400;
    tick();
    chk("rst pre dmem_req", 32'(dmem_req), 32'd1);
    #2;
    reset = 1'b1;
    idle_inputs();
    #1;
    chk("rst async dmem_req", 32'(dmem_req), 32'd0);
    chk("rst async dmem_addr", dmem_addr, 32'd0);
    chk("rst async bus_err", 32'(bus_err), 32'd0);
    tick();
    reset = 1'b0;
    dmem_ack = 1; dmem_rdata = 32'h7777_7777;
    tick();
    dmem_ack = 0;
    chk("rst late ack data", data, 32'd0);
    chk("rst late ack stall_m", 32'(stall_m), 32'd0);
    chk("rst late ack dmem_req", 32'(dmem_req), 32'd0);
    chk("rst late ack bus_err", 32'(bus_err), 32'd0);
    tick();

    // Misaligned load: no request, one stall cycle, bus_err
    mem_rd_m = 1; reg_wr_m = 1; alu_result_m = 32'h102;
    #1;
    chk("mis detect stall_m", 32'(stall_m), 32'd1);
    chk("mis detect reg_wr_out", 32'(reg_wr_out), 32'd0);
    tick();
    chk("mis done dmem_req", 32'(dmem_req), 32'd0);
    chk("mis done stall_m", 32'(stall_m), 32'd0);
    chk("mis done data", data, 32'd0);
    chk("mis done reg_wr_out", 32'(reg_wr_out), 32'd1);
    chk("mis done bus_err", 32'(bus_err), 32'd1);
    idle_inputs();
    tick();
    chk("mis sticky bus_err", 32'(bus_err), 32'd1);
    pulse_reset();
    chk("reset clears bus_err", 32'(bus_err), 32'd0);

    // Load with no ack: abort after 16 ACCESS cycles
    mem_rd_m = 1; reg_wr_m = 1; alu_result_m = 32'h500;
    tick();
    n = 0;
    while (dmem_req && n < 40) begin
      n++;
      tick();
    end
    chk("to access cycles", 32'(n), 32'd16);
    chk("to done stall_m", 32'(stall_m), 32'd0);
    chk("to done data", data, 32'd0);
    chk("to done bus_err", 32'(bus_err), 32'd1);
    idle_inputs();
    repeat (3) tick();
    chk("to sticky bus_err", 32'(bus_err), 32'd1);
    chk("to idle dmem_req", 32'(dmem_req), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
